// File: rtl/id_free_list_pkg.sv
// Shared types for the ID free list: FSM state encoding and default sizing.
package id_free_list_pkg;

  localparam int unsigned DEFAULT_DEPTH        = 64;
  localparam int unsigned DEFAULT_RETURN_PORTS = 2;

  typedef logic [$clog2(DEFAULT_DEPTH)-1:0] id_t;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/id_free_list_ram.sv
// Free-ID storage: one asynchronous read port, NUM_WR synchronous write ports
// whose addresses are disjoint by construction.
module id_free_list_ram #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned NUM_WR = 3,
  localparam int unsigned IDW   = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic [NUM_WR-1:0]          we,
  input  logic [NUM_WR-1:0][IDW-1:0] waddr,
  input  logic [NUM_WR-1:0][IDW-1:0] wdata,
  input  logic [IDW-1:0]             raddr,
  output logic [IDW-1:0]             rdata
);

  logic [IDW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int p = 0; p < int'(NUM_WR); p++) begin
      if (we[p]) mem[waddr[p]] <= wdata[p];
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/id_free_list.sv
// Circular free list of IDs: self-fills after reset, issues one ID per cycle,
// and accepts up to NUM_RETURN_PORTS returned IDs per cycle.
module id_free_list
  import id_free_list_pkg::*;
#(
  parameter int unsigned DEPTH            = DEFAULT_DEPTH,
  parameter int unsigned NUM_RETURN_PORTS = DEFAULT_RETURN_PORTS,
  localparam int unsigned IDW             = $clog2(DEPTH),
  localparam int unsigned CW              = $clog2(DEPTH + 1)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 alloc_pop,
  output logic                                 alloc_valid,
  output logic [IDW-1:0]                       alloc_id,
  output logic                                 alloc_toggle,
  input  logic [NUM_RETURN_PORTS-1:0]          return_valid,
  input  logic [NUM_RETURN_PORTS-1:0][IDW-1:0] return_id,
  output logic                                 init_done,
  output logic [CW-1:0]                        free_count
);

  localparam int unsigned NW        = NUM_RETURN_PORTS + 1;
  localparam int unsigned RW        = $clog2(NUM_RETURN_PORTS + 1);
  localparam int unsigned INIT_PORT = NUM_RETURN_PORTS;

  state_t         state, state_n;
  logic [IDW-1:0] read_ptr, read_ptr_n;
  logic [IDW-1:0] write_ptr, write_ptr_n;
  logic [IDW-1:0] init_ctr, init_ctr_n;
  logic [CW-1:0]  count;
  logic [CW:0]    count_n;
  logic           init_done_n;
  logic           alloc_valid_n;
  logic [RW-1:0]  num_ret;

  logic [NW-1:0]          wr_en;
  logic [NW-1:0][IDW-1:0] wr_addr;
  logic [NW-1:0][IDW-1:0] wr_data;

  assign alloc_toggle = alloc_pop & alloc_valid;
  assign free_count   = count;

  // Next state: init fill, pops, and packed return writes
  always_comb begin
    state_n     = state;
    read_ptr_n  = read_ptr;
    write_ptr_n = write_ptr;
    init_ctr_n  = init_ctr;
    init_done_n = init_done;
    count_n     = {1'b0, count};
    num_ret     = '0;
    wr_en       = '0;
    wr_addr     = '0;
    wr_data     = '0;

    for (int j = 0; j < int'(NUM_RETURN_PORTS); j++) begin
      wr_addr[j] = write_ptr + IDW'(num_ret);
      wr_data[j] = return_id[j];
      if (state == ST_RUN && return_valid[j]) begin
        wr_en[j] = 1'b1;
        num_ret  = num_ret + RW'(1);
      end
    end
    wr_addr[INIT_PORT] = write_ptr;
    wr_data[INIT_PORT] = init_ctr;

    case (state)
      ST_INIT: begin
        wr_en[INIT_PORT] = 1'b1;
        write_ptr_n      = write_ptr + IDW'(1);
        init_ctr_n       = init_ctr + IDW'(1);
        count_n          = {1'b0, count} + (CW+1)'(1);
        if (init_ctr == IDW'(DEPTH - 1)) begin
          state_n     = ST_RUN;
          init_done_n = 1'b1;
        end
      end
      ST_RUN: begin
        if (alloc_toggle) read_ptr_n = read_ptr + IDW'(1);
        write_ptr_n = write_ptr + IDW'(num_ret);
        count_n     = {1'b0, count} + (CW+1)'(num_ret) - (CW+1)'(alloc_toggle);
      end
      default: state_n = ST_INIT;
    endcase

    alloc_valid_n = (state_n == ST_RUN) && (count_n != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_INIT;
      read_ptr    <= '0;
      write_ptr   <= '0;
      init_ctr    <= '0;
      count       <= '0;
      init_done   <= 1'b0;
      alloc_valid <= 1'b0;
    end else begin
      state       <= state_n;
      read_ptr    <= read_ptr_n;
      write_ptr   <= write_ptr_n;
      init_ctr    <= init_ctr_n;
      count       <= CW'(count_n);
      init_done   <= init_done_n;
      alloc_valid <= alloc_valid_n;
    end
  end

  id_free_list_ram #(
    .DEPTH  (DEPTH),
    .NUM_WR (NW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (read_ptr),
    .rdata (alloc_id)
  );

  // Returns during the fill would collide with the init writer
  assert property (@(posedge clk) disable iff (!rst_n)
    (state == ST_INIT) |-> (return_valid == '0))
    else $error("return_valid asserted during init");

  // Each ID exists once, so the list can never overfill
  assert property (@(posedge clk) disable iff (!rst_n)
    count_n <= (CW+1)'(DEPTH))
    else $error("free list count overflow");

endmodule

// File: tb/tb_id_free_list.sv
// Directed bench for id_free_list: a stimulus thread queues expected IDs and a
// monitor compares alloc_id against the queue on every alloc_toggle.
module tb_id_free_list;
  import id_free_list_pkg::*;

  localparam int unsigned NRP = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                alloc_pop = 1'b0;
  logic                alloc_valid;
  logic [5:0]          alloc_id;
  logic                alloc_toggle;
  logic [NRP-1:0]      return_valid = '0;
  logic [NRP-1:0][5:0] return_id = '0;
  logic                init_done;
  logic [6:0]          free_count;

  int         checks = 0;
  int         errors = 0;
  int         mon_pops = 0;
  logic [5:0] exp_q[$];
  logic [5:0] perm[64];

  id_free_list #(.DEPTH(64), .NUM_RETURN_PORTS(NRP)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alloc_pop    (alloc_pop),
    .alloc_valid  (alloc_valid),
    .alloc_id     (alloc_id),
    .alloc_toggle (alloc_toggle),
    .return_valid (return_valid),
    .return_id    (return_id),
    .init_done    (init_done),
    .free_count   (free_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: sampled mid-cycle, away from the active edge
  always @(negedge clk) begin
    if (alloc_toggle) begin
      mon_pops++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got id %0d expected no pop", alloc_id);
      end else begin
        check("pop_id", 32'(alloc_id), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ret2(input logic v0, input logic [5:0] i0, input logic v1, input logic [5:0] i1);
    return_valid = {v1, v0};
    return_id[0] = i0;
    return_id[1] = i1;
    if (v0) exp_q.push_back(i0);
    if (v1) exp_q.push_back(i1);
    tick();
    return_valid = '0;
  endtask

  task automatic load_init_model();
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(6'(i));
  endtask

  task automatic wait_init();
    for (int i = 1; i <= 64; i++) begin
      tick();
      if (i == 63) begin
        check("init_done_early", 32'(init_done), 32'd0);
        check("init_valid_low", 32'(alloc_valid), 32'd0);
        check("init_count_63", 32'(free_count), 32'd63);
      end
    end
    check("init_done", 32'(init_done), 32'd1);
    check("init_free_count", 32'(free_count), 32'd64);
    check("init_valid", 32'(alloc_valid), 32'd1);
    check("init_head", 32'(alloc_id), 32'd0);
  endtask

  task automatic drain(input int n);
    int start;
    start = mon_pops;
    alloc_pop = 1'b1;
    repeat (n) tick();
    alloc_pop = 1'b0;
    check("drain_pops", 32'(mon_pops - start), 32'(n));
  endtask

  initial begin
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    load_init_model();
    repeat (3) tick();
    rst_n = 1'b1;
    wait_init();

    // Drain the whole initial fill in order
    drain(64);
    check("empty_valid", 32'(alloc_valid), 32'd0);
    check("empty_count", 32'(free_count), 32'd0);
    check("empty_model", 32'(exp_q.size()), 32'd0);

    // Pop on an empty list is ignored
    alloc_pop = 1'b1;
    tick();
    alloc_pop = 1'b0;
    check("empty_pop_count", 32'(free_count), 32'd0);

    // Two returns into the empty list; not visible until the next cycle
    return_valid = 2'b11;
    return_id[0] = 6'd5;
    return_id[1] = 6'd9;
    exp_q.push_back(6'd5);
    exp_q.push_back(6'd9);
    #1 check("no_bypass", 32'(alloc_valid), 32'd0);
    tick();
    return_valid = '0;
    check("ret2_valid", 32'(alloc_valid), 32'd1);
    check("ret2_head", 32'(alloc_id), 32'd5);
    check("ret2_count", 32'(free_count), 32'd2);
    drain(1);
    check("ret2_second", 32'(alloc_id), 32'd9);
    check("ret2_count1", 32'(free_count), 32'd1);
    drain(1);

    // count=1 with head 7: pop and return on port 1 in the same cycle
    ret2(1'b1, 6'd7, 1'b0, 6'd0);
    check("one_head", 32'(alloc_id), 32'd7);
    alloc_pop = 1'b1;
    ret2(1'b0, 6'd0, 1'b1, 6'd3);
    alloc_pop = 1'b0;
    check("pop_ret_count", 32'(free_count), 32'd1);
    check("pop_ret_head", 32'(alloc_id), 32'd3);
    drain(1);
    check("pop_ret_empty", 32'(free_count), 32'd0);

    // Refill with a permutation, drain 60, return them shuffled across the wrap
    for (int i = 0; i < 64; i++) perm[i] = 6'((i * 37 + 11) % 64);
    for (int k = 0; k < 32; k++) ret2(1'b1, perm[2*k], 1'b1, perm[2*k+1]);
    check("refill_count", 32'(free_count), 32'd64);
    check("refill_head", 32'(alloc_id), 32'(perm[0]));
    drain(60);
    check("drain60_count", 32'(free_count), 32'd4);
    check("drain60_head", 32'(alloc_id), 32'(perm[60]));
    for (int k = 0; k < 30; k++)
      ret2(1'b1, perm[(2*k*13 + 5) % 60], 1'b1, perm[((2*k+1)*13 + 5) % 60]);
    check("wrap_count", 32'(free_count), 32'd64);
    drain(64);
    check("wrap_empty", 32'(free_count), 32'd0);
    check("wrap_model", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset with ten free IDs
    for (int k = 0; k < 5; k++) ret2(1'b1, 6'(2*k), 1'b1, 6'(2*k+1));
    check("pre_reset_count", 32'(free_count), 32'd10);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_valid", 32'(alloc_valid), 32'd0);
    check("rst_async_done", 32'(init_done), 32'd0);
    check("rst_async_count", 32'(free_count), 32'd0);
    load_init_model();
    repeat (2) tick();
    rst_n = 1'b1;
    wait_init();
    drain(3);
    check("post_reset_head", 32'(alloc_id), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
